argmin_stream: RTL and testbench

//  Streaming argmin over NUM_CANDS unsigned costs delivered LANES per beat

---
 rtl/argmin_stream_pkg.sv | 23 ++
 rtl/argmin_lanes.sv | 41 ++++
 rtl/argmin_stream.sv | 125 ++++++++++++
 tb/tb_argmin_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmin_stream_pkg.sv
// Shared compare/select helpers for the streaming argmin.
package argmin_stream_pkg;

  // Widest supported cost. Callers zero-extend narrower costs to this width.
  localparam int CMP_W = 64;

  // The "second" value used when a group holds a single candidate.
  localparam logic [CMP_W-1:0] SAT_SECOND = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } state_e;

  // Unsigned compare-select. Returns 1 only when b is strictly smaller.
  // Candidate a must be the lower index, so on a tie a is kept.
  function automatic logic take_b(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b);
    return (b < a);
  endfunction

endpackage

// File: rtl/argmin_lanes.sv
// Combinational reduction of one beat: min, winning lane and second-smallest.
module argmin_lanes
  import argmin_stream_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int LIDX_W = 2
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]       o_min,
  output logic [LIDX_W-1:0]      o_idx,
  output logic [WIDTH-1:0]       o_second
);

  logic [WIDTH-1:0] w_v;
  logic [WIDTH-1:0] w_hi;

  // Fold lanes in ascending order so that on a tie the earlier (lower) lane wins.
  // A lone lane's own second is saturated, so the merge reduces to
  // second = min(second, max(min, lane)).
  always_comb begin
    w_v      = '0;
    w_hi     = '0;
    o_min    = i_data[0 +: WIDTH];
    o_idx    = '0;
    o_second = WIDTH'(SAT_SECOND);
    for (int k = 1; k < LANES; k++) begin
      w_v = i_data[k*WIDTH +: WIDTH];
      if (take_b(CMP_W'(o_min), CMP_W'(w_v))) begin
        w_hi  = o_min;
        o_min = w_v;
        o_idx = LIDX_W'(k);
      end else begin
        w_hi  = w_v;
      end
      if (!take_b(CMP_W'(w_hi), CMP_W'(o_second)))
        o_second = w_hi;
    end
  end

endmodule

// File: rtl/argmin_stream.sv
// Streaming argmin over NUM_CANDS costs, LANES per beat, valid/ready in and out.
module argmin_stream
  import argmin_stream_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NUM_CANDS = 64,
  parameter  int LANES     = 4,
  localparam int IDX_W     = (NUM_CANDS > 1) ? $clog2(NUM_CANDS) : 1,
  localparam int BEATS     = NUM_CANDS / LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_min,
  output logic [IDX_W-1:0]       out_idx,
  output logic [WIDTH-1:0]       out_second
);

  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc_min, r_acc_sec;
  logic [IDX_W-1:0]   r_acc_idx;
  logic [WIDTH-1:0]   r_out_min, r_out_sec;
  logic [IDX_W-1:0]   r_out_idx;

  logic [WIDTH-1:0]   w_lane_min, w_lane_sec;
  logic [LIDX_W-1:0]  w_lane_idx;
  logic [IDX_W-1:0]   w_b_idx;
  logic [WIDTH-1:0]   w_new_min, w_new_sec, w_hi, w_lo;
  logic [IDX_W-1:0]   w_new_idx;
  logic               w_fire, w_last;

  argmin_lanes #(.WIDTH(WIDTH), .LANES(LANES), .LIDX_W(LIDX_W)) u_lanes (
    .i_data   (in_data),
    .o_min    (w_lane_min),
    .o_idx    (w_lane_idx),
    .o_second (w_lane_sec)
  );

  // While a result is held the beat counter is always 0, so HOLD never overlaps ACCUM.
  assign out_valid  = (r_state == ST_HOLD);
  assign in_ready   = !out_valid || out_ready;
  assign w_fire     = in_valid && in_ready;
  assign w_last     = w_fire && (r_cnt == CNT_W'(BEATS - 1));
  assign out_min    = r_out_min;
  assign out_idx    = r_out_idx;
  assign out_second = r_out_sec;

  // Global index of the beat's winner; the product is at most NUM_CANDS-LANES,
  // so it fits IDX_W.
  assign w_b_idx = IDX_W'(r_cnt) * IDX_W'(LANES) + IDX_W'(w_lane_idx);

  // Merge the beat with the accumulator (earlier beats win ties); beat 0 loads fresh.
  always_comb begin
    w_new_min = w_lane_min;
    w_new_idx = w_b_idx;
    w_new_sec = w_lane_sec;
    w_hi      = '0;
    w_lo      = '0;
    if (r_cnt != '0) begin
      if (take_b(CMP_W'(r_acc_min), CMP_W'(w_lane_min))) begin
        w_new_min = w_lane_min;
        w_new_idx = w_b_idx;
        w_hi      = r_acc_min;
      end else begin
        w_new_min = r_acc_min;
        w_new_idx = r_acc_idx;
        w_hi      = w_lane_min;
      end
      w_lo      = take_b(CMP_W'(r_acc_sec), CMP_W'(w_lane_sec)) ? w_lane_sec : r_acc_sec;
      w_new_sec = take_b(CMP_W'(w_hi), CMP_W'(w_lo)) ? w_lo : w_hi;
    end
  end

  // Next-state: a completing frame always lands in HOLD, even while the old result drains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_last) w_state_nxt = ST_HOLD;
                else if (w_fire) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_last) w_state_nxt = ST_HOLD;
                else if (w_fire) w_state_nxt = ST_ACCUM;
                else if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Beat counter, accumulator and output register; a reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc_min <= '0;
      r_acc_idx <= '0;
      r_acc_sec <= '0;
      r_out_min <= '0;
      r_out_idx <= '0;
      r_out_sec <= '0;
    end else if (w_fire) begin
      r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_acc_min <= w_new_min;
      r_acc_idx <= w_new_idx;
      r_acc_sec <= w_new_sec;
      if (w_last) begin
        r_out_min <= w_new_min;
        r_out_idx <= w_new_idx;
        r_out_sec <= w_new_sec;
      end
    end
  end

endmodule

// File: tb/tb_argmin_stream.sv
// Bench for argmin_stream: N=8/L=4 main instance, N=4/L=4 full-rate instance.
module tb_argmin_stream;
  localparam int W = 32, N = 8, L = 4, IW = 3, NB = 4, IWB = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [L*W-1:0] in_data = '0;
  logic [W-1:0] out_min, out_second;
  logic [IW-1:0] out_idx;

  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [L*W-1:0] b_in_data = '0;
  logic [W-1:0] b_out_min, b_out_second;
  logic [IWB-1:0] b_out_idx;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  argmin_stream #(.WIDTH(W), .NUM_CANDS(N), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_idx(out_idx),
    .out_second(out_second));

  argmin_stream #(.WIDTH(W), .NUM_CANDS(NB), .LANES(L)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_min(b_out_min), .out_idx(b_out_idx),
    .out_second(b_out_second));

  // Reference: smallest value, first index holding it, smallest of all other indices.
  function automatic void ref_model(input logic [W-1:0] c[$], output logic [W-1:0] mn,
                                    output int idx, output logic [W-1:0] sec);
    mn = c[0]; idx = 0;
    for (int i = 1; i < c.size(); i++) if (c[i] < mn) begin mn = c[i]; idx = i; end
    sec = '1;
    for (int i = 0; i < c.size(); i++) if (i != idx && c[i] < sec) sec = c[i];
  endfunction

  function automatic logic [L*W-1:0] pack(input logic [W-1:0] c[$], input int beat);
    logic [L*W-1:0] d;
    for (int k = 0; k < L; k++) d[k*W +: W] = c[beat*L + k];
    return d;
  endfunction

  function automatic logic [W-1:0] rnd_cost();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '1;
    if (sel < 6)  return W'($urandom_range(0, 7));
    return W'($urandom);
  endfunction

  // Present one beat until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [L*W-1:0] d, input bit rnd_rdy);
    bit done; int n;
    done = 1'b0; n = 0;
    while (!done) begin
      @(negedge clk);
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1; in_data = d;
      #1;
      done = in_ready;
      @(posedge clk);
      n++;
      if (!done && n > 1000) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        done = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] c[$], input bit gaps, input bit rnd_rdy);
    for (int b = 0; b < N/L; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
      send_beat(pack(c, b), rnd_rdy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_min !== '0 || out_idx !== '0 || out_second !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: valid=%b min=%h idx=%0d sec=%h rdy=%b, required 0 0 0 0 1",
               out_valid, out_min, out_idx, out_second, in_ready);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_out_min !== '0 || b_out_idx !== '0 || b_out_second !== '0) begin
      errors++;
      $display("FAIL reset_b: valid=%b min=%h idx=%0d sec=%h, required 0 0 0 0",
               b_out_valid, b_out_min, b_out_idx, b_out_second);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] q[$];
    q = '{32'd9, 32'd3, 32'd7, 32'd5, 32'd6, 32'd3, 32'd8, 32'd4};
    send_beat(pack(q, 0), 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: out_valid=%b, required 0", out_valid);
    end
    send_beat(pack(q, 1), 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'd3 || out_idx !== 3'd1 || out_second !== 32'd3) begin
      errors++;
      $display("FAIL basic_tie: valid=%b min=%0d idx=%0d sec=%0d, required 1 3 1 3",
               out_valid, out_min, out_idx, out_second);
    end
    q = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd2, 32'd70};
    send_frame(q, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'd2 || out_idx !== 3'd6 || out_second !== 32'd10) begin
      errors++;
      $display("FAIL basic_cross: valid=%b min=%0d idx=%0d sec=%0d, required 1 2 6 10",
               out_valid, out_min, out_idx, out_second);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drop_valid: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] qa[$], qb[$], amn, bmn, asec, bsec;
    int aidx, bidx;
    for (int i = 0; i < N; i++) begin qa.push_back(rnd_cost()); qb.push_back(rnd_cost()); end
    ref_model(qa, amn, aidx, asec);
    ref_model(qb, bmn, bidx, bsec);
    out_ready = 1'b0;
    send_frame(qa, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = pack(qb, 0);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_min !== amn || out_idx !== IW'(aidx) || out_second !== asec) begin
        errors++;
        $display("FAIL hold_%0d: rdy=%b valid=%b min=%h idx=%0d sec=%h, required 0 1 %h %0d %h",
                 c, in_ready, out_valid, out_min, out_idx, out_second, amn, aidx, asec);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL release_consume: out_valid=%b, required 0", out_valid);
    end
    send_beat(pack(qb, 1), 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_min !== bmn || out_idx !== IW'(bidx) || out_second !== bsec) begin
      errors++;
      $display("FAIL release_next: valid=%b min=%h idx=%0d sec=%h, required 1 %h %0d %h",
               out_valid, out_min, out_idx, out_second, bmn, bidx, bsec);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q[$];
    q = '{32'd1, 32'd1, 32'd1, 32'd1};
    send_beat(pack(q, 0), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_min !== '0 || out_idx !== '0 || out_second !== '0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b min=%h idx=%0d sec=%h, required 0 0 0 0",
               out_valid, out_min, out_idx, out_second);
    end
    @(negedge clk);
    rst = 1'b0;
    q = '{32'd8, 32'd8, 32'd8, 32'd8, 32'd8, 32'd8, 32'd8, 32'd0};
    send_frame(q, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'd0 || out_idx !== 3'd7 || out_second !== 32'd8) begin
      errors++;
      $display("FAIL midreset_frame: valid=%b min=%0d idx=%0d sec=%0d, required 1 0 7 8",
               out_valid, out_min, out_idx, out_second);
    end
  endtask

  task automatic test_random_gaps();
    logic [W-1:0] q[$], mn, sec;
    int idx;
    for (int f = 0; f < 100; f++) begin
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(rnd_cost());
      ref_model(q, mn, idx, sec);
      send_frame(q, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_min !== mn || out_idx !== IW'(idx) || out_second !== sec) begin
        errors++;
        $display("FAIL random_frame_%0d: valid=%b min=%h idx=%0d sec=%h, required 1 %h %0d %h",
                 f, out_valid, out_min, out_idx, out_second, mn, idx, sec);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_edge();
    logic [W-1:0] q[$];
    for (int i = 0; i < N; i++) q.push_back('1);
    send_frame(q, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'hFFFFFFFF || out_idx !== 3'd0 || out_second !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL edge_all_ones: valid=%b min=%h idx=%0d sec=%h, required 1 ffffffff 0 ffffffff",
               out_valid, out_min, out_idx, out_second);
    end
  endtask

  // Single-beat frames: one result every cycle with no bubbles.
  task automatic test_full_rate();
    logic [W-1:0] q[$], emn[6], esec[6];
    int eidx[6];
    for (int f = 0; f <= 6; f++) begin
      @(negedge clk);
      if (f > 0) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_min !== emn[f-1] || b_out_idx !== IWB'(eidx[f-1]) || b_out_second !== esec[f-1]) begin
          errors++;
          $display("FAIL fullrate_%0d: valid=%b min=%h idx=%0d sec=%h, required 1 %h %0d %h",
                   f-1, b_out_valid, b_out_min, b_out_idx, b_out_second, emn[f-1], eidx[f-1], esec[f-1]);
        end
      end
      if (f < 6) begin
        q.delete();
        for (int i = 0; i < NB; i++) q.push_back(rnd_cost());
        ref_model(q, emn[f], eidx[f], esec[f]);
        b_in_valid = 1'b1; b_in_data = pack(q, 0);
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
          errors++; $display("FAIL fullrate_ready_%0d: in_ready=%b, required 1", f, b_in_ready);
        end
      end else begin
        b_in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++; $display("FAIL fullrate_drain: out_valid=%b, required 0", b_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_random_gaps();
    test_edge();
    test_full_rate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
